hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard sequencer for the 16-bit MIPS core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve. It stalls the front end for one cycle on a load-use dependency, flushes younger stages when a branch resolves taken in MEM, and freezes IF/ID/EX while a multi-cycle EX operation (multiply/divide) completes. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MULTI_CYCLES, 4: total EX occupancy of a multi-cycle op, in cycles. Legal range 2..16.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_src1, id_src2  in  5 each  source registers of the instruction in ID
- id_uses_src2  in  1  ID instruction reads src2 (R-type, store, branch)
- ex_dest_reg  in  5  destination register of the instruction in EX
- ex_reg_write  in  1  EX instruction writes the register file
- ex_mem2reg  in  1  EX instruction is a load
- ex_multi_start  in  1  EX instruction is a multi-cycle op in its first EX cycle
- mem_branch_taken  in  1  branch in MEM resolved taken
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_mem_bubble  out  1  load NOP into EX/MEM
- ex_busy  out  1  multi-cycle unit is occupying EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- States: RUN, LOAD_STALL, MULTI. The state register is encoded in the package.
- Default outputs (no event): pc_write=1, if_id_write=1, id_ex_write=1. All flush and bubble outputs are 0, and ex_busy=0.
- Load-use condition: ex_mem2reg & ex_reg_write & ex_dest_reg≠0 & (ex_dest_reg==id_src1 | (id_uses_src2 & ex_dest_reg==id_src2)).
- Register 0 is never a hazard.
- Events are prioritised, highest first: branch, multi, load-use.
- RUN:
  - mem_branch_taken: if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1. Next state is RUN. A simultaneous ex_multi_start or load-use is ignored, because those instructions are squashed.
  - else ex_multi_start: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1, ex_busy=1. The down-counter loads MULTI_CYCLES-2. Next state is MULTI.
  - else load-use: pc_write=0, if_id_write=0, id_ex_bubble=1. Next state is LOAD_STALL.
- LOAD_STALL: default outputs; the dependency is now served by forwarding from MEM.
  - Next state is RUN. A new load-use is not re-detected in this cycle.
  - mem_branch_taken is impossible here, since the bubble occupies EX. If it is asserted anyway, the branch action applies.
- MULTI: same freeze outputs as MULTI entry.
  - When the counter is 0, the op's final EX cycle gets default outputs with ex_busy=1, and the next state is RUN.
  - Otherwise the counter decrements.
  - mem_branch_taken cannot occur in MULTI because MEM holds bubbles. If it is asserted, it is ignored.
- stall_cnt increments on every cycle with pc_write=0 and saturates at all-ones. It is cleared only by rst.

## Timing
- Outputs are combinational (Mealy) from the registered state/counter and current inputs. Response has zero-cycle latency in the detecting cycle.
- Load-use: exactly one stall cycle, then normal flow.
- Multi-cycle op: pc_write is low for MULTI_CYCLES-1 consecutive cycles, starting in the ex_multi_start cycle. ex_busy is high for MULTI_CYCLES cycles.
- Branch flush lasts exactly one cycle and has no state change.
- Reset: while rst=1:
  - outputs are pc_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1, if_id_write=1, id_ex_write=1, ex_busy=0
  - at the edge, state becomes RUN and the counter and stall_cnt become 0
- rst asserted mid-MULTI or mid-LOAD_STALL aborts the sequence at the next edge, with no residual stall.

## Structure
- Package hazard_pkg holds:
  - the state encoding (RUN=2'b00, LOAD_STALL=2'b01, MULTI=2'b10)
  - the MULTI_CYCLES default
  - the register-0 constant
- One sub-module, multi_cycle_timer: load, decrement and zero-flag down-counter, width clog2(16)=4.
- The remainder, a state register plus output decode, lives in hazard_controller.

## Test plan
- Load r3 in EX, ID reads r3 as src1: one cycle of pc_write=0, id_ex_bubble=1, then RUN; stall_cnt=1.
- Load r0 in EX, ID reads r0: no stall; load r5, ID src2=r5 with id_uses_src2=0: no stall.
- ex_multi_start with MULTI_CYCLES=4: pc_write low for 3 cycles, ex_busy high 4 cycles, stall_cnt=3.
- mem_branch_taken together with ex_multi_start and a load-use: only the flush is issued (if_id_flush, id_ex_bubble, ex_mem_bubble=1), the state stays RUN, and stall_cnt is unchanged.
- rst pulse in the second MULTI cycle: reset outputs during rst, then defaults the next cycle with state RUN and stall_cnt=0.
- Force stall_cnt near max (CNT_W=4, 16 stall cycles): the counter holds at 4'hF.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | hazard_pkg : shared encodings and constants for the hazard sequencer      |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package hazard_pkg;

  localparam logic [1:0] c_RUN        = 2'b00;
  localparam logic [1:0] c_LOAD_STALL = 2'b01;
  localparam logic [1:0] c_MULTI      = 2'b10;

  localparam int         c_MULTI_CYCLES_DEF = 4;
  localparam int         c_TIMER_W          = $clog2(16);
  localparam logic [4:0] c_REG_ZERO         = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic ex_busy;
  } hz_ctrl_t;

  localparam hz_ctrl_t c_CTL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                         id_ex_write: 1'b1, id_ex_bubble: 1'b0,
                                         ex_mem_bubble: 1'b0, ex_busy: 1'b0};
  localparam hz_ctrl_t c_CTL_RESET   = '{pc_write: 1'b0, if_id_write: 1'b1, if_id_flush: 1'b1,
                                         id_ex_write: 1'b1, id_ex_bubble: 1'b1,
                                         ex_mem_bubble: 1'b1, ex_busy: 1'b0};
  localparam hz_ctrl_t c_CTL_FLUSH   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                         id_ex_write: 1'b1, id_ex_bubble: 1'b1,
                                         ex_mem_bubble: 1'b1, ex_busy: 1'b0};
  localparam hz_ctrl_t c_CTL_FREEZE  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_write: 1'b0, id_ex_bubble: 1'b0,
                                         ex_mem_bubble: 1'b1, ex_busy: 1'b1};
  localparam hz_ctrl_t c_CTL_LUSTALL = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_write: 1'b1, id_ex_bubble: 1'b1,
                                         ex_mem_bubble: 1'b0, ex_busy: 1'b0};
  // Final EX cycle of a multi-cycle op: pipeline advances, unit still busy
  localparam hz_ctrl_t c_CTL_LAST    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                         id_ex_write: 1'b1, id_ex_bubble: 1'b0,
                                         ex_mem_bubble: 1'b0, ex_busy: 1'b1};

  function automatic logic f_load_use(
    input logic       mem2reg,
    input logic       reg_write,
    input logic [4:0] dest,
    input logic [4:0] src1,
    input logic [4:0] src2,
    input logic       uses_src2
  );
    return mem2reg && reg_write && (dest != c_REG_ZERO) &&
           ((dest == src1) || (uses_src2 && (dest == src2)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_timer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | multi_cycle_timer : loadable down-counter with zero flag                  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module multi_cycle_timer
  import hazard_pkg::*;
#(
  parameter int WIDTH = c_TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | hazard_controller : load-use stall, branch flush, multi-cycle EX freeze   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MULTI_CYCLES = c_MULTI_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_uses_src2,
  input  logic [4:0]       ex_dest_reg,
  input  logic             ex_reg_write,
  input  logic             ex_mem2reg,
  input  logic             ex_multi_start,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             ex_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Entry cycle and final cycle are not counted by the timer
  localparam logic [c_TIMER_W-1:0] c_LOAD_VAL = c_TIMER_W'(MULTI_CYCLES - 2);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;
  logic             w_tmr_load;
  logic             w_tmr_dec;
  logic             w_tmr_zero;
  hz_ctrl_t         w_ctl;

  assign w_load_use = f_load_use(ex_mem2reg, ex_reg_write, ex_dest_reg,
                                 id_src1, id_src2, id_uses_src2);

  multi_cycle_timer #(
    .WIDTH (c_TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (c_LOAD_VAL),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_ctl        = c_CTL_DEFAULT;
    w_next_state = c_RUN;
    w_tmr_load   = 1'b0;
    w_tmr_dec    = 1'b0;
    if (rst) begin
      w_ctl = c_CTL_RESET;
    end else begin
      case (r_state)
        c_RUN: begin
          // Branch squashes the younger multi-op / load-use consumer
          if (mem_branch_taken) begin
            w_ctl = c_CTL_FLUSH;
          end else if (ex_multi_start) begin
            w_ctl        = c_CTL_FREEZE;
            w_tmr_load   = 1'b1;
            w_next_state = c_MULTI;
          end else if (w_load_use) begin
            w_ctl        = c_CTL_LUSTALL;
            w_next_state = c_LOAD_STALL;
          end
        end
        c_LOAD_STALL: begin
          if (mem_branch_taken) begin
            w_ctl = c_CTL_FLUSH;
          end
        end
        c_MULTI: begin
          if (w_tmr_zero) begin
            w_ctl = c_CTL_LAST;
          end else begin
            w_ctl        = c_CTL_FREEZE;
            w_tmr_dec    = 1'b1;
            w_next_state = c_MULTI;
          end
        end
        default: begin
          w_next_state = c_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (!w_ctl.pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign pc_write      = w_ctl.pc_write;
  assign if_id_write   = w_ctl.if_id_write;
  assign if_id_flush   = w_ctl.if_id_flush;
  assign id_ex_write   = w_ctl.id_ex_write;
  assign id_ex_bubble  = w_ctl.id_ex_bubble;
  assign ex_mem_bubble = w_ctl.ex_mem_bubble;
  assign ex_busy       = w_ctl.ex_busy;
  assign stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_hazard_controller : randomized + directed bench with behavioural model |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_hazard_controller;

  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, ex_dest_reg;
  logic       id_uses_src2, ex_reg_write, ex_mem2reg, ex_multi_start, mem_branch_taken;

  logic        a_pc, a_ifw, a_iff, a_idw, a_idb, a_exb, a_busy;
  logic        b_pc, b_ifw, b_iff, b_idw, b_idb, b_exb, b_busy;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [6:0]  ctl_a, ctl_b;

  // ctl vector order: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, ex_busy
  assign ctl_a = {a_pc, a_ifw, a_iff, a_idw, a_idb, a_exb, a_busy};
  assign ctl_b = {b_pc, b_ifw, b_iff, b_idw, b_idb, b_exb, b_busy};

  always #5 clk = ~clk;

  hazard_controller #(.MULTI_CYCLES(MC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write), .ex_mem2reg(ex_mem2reg),
    .ex_multi_start(ex_multi_start), .mem_branch_taken(mem_branch_taken),
    .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_write(a_idw),
    .id_ex_bubble(a_idb), .ex_mem_bubble(a_exb), .ex_busy(a_busy), .stall_cnt(cnt_a));

  hazard_controller #(.MULTI_CYCLES(MC), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write), .ex_mem2reg(ex_mem2reg),
    .ex_multi_start(ex_multi_start), .mem_branch_taken(mem_branch_taken),
    .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_write(b_idw),
    .id_ex_bubble(b_idb), .ex_mem_bubble(b_exb), .ex_busy(b_busy), .stall_cnt(cnt_b));

  int checks = 0;
  int errors = 0;

  // Behavioural model: cycles left in a multi-op, and "previous cycle was a load stall"
  int          m_multi_left, n_multi_left;
  bit          m_post_load, n_post_load;
  longint      m_cnt, n_cnt;
  logic [6:0]  exp_ctl;
  logic [15:0] exp_a;
  logic [3:0]  exp_b;

  function automatic void model_eval();
    bit lu;
    lu = ex_mem2reg && ex_reg_write && (ex_dest_reg != 0) &&
         ((ex_dest_reg == id_src1) || (id_uses_src2 && (ex_dest_reg == id_src2)));
    exp_a        = m_cnt[15:0];
    exp_b        = (m_cnt > 15) ? 4'hF : m_cnt[3:0];
    exp_ctl      = 7'b1101000;
    n_post_load  = 1'b0;
    n_multi_left = m_multi_left;
    n_cnt        = m_cnt;
    if (rst) begin
      exp_ctl      = 7'b0111110;
      n_multi_left = 0;
      n_cnt        = 0;
    end else if (m_multi_left > 0) begin
      exp_ctl      = (m_multi_left == 1) ? 7'b1101001 : 7'b0000011;
      n_multi_left = m_multi_left - 1;
    end else if (mem_branch_taken) begin
      exp_ctl = 7'b1111110;
    end else if (!m_post_load && ex_multi_start) begin
      exp_ctl      = 7'b0000011;
      n_multi_left = MC - 1;
    end else if (!m_post_load && lu) begin
      exp_ctl     = 7'b0001100;
      n_post_load = 1'b1;
    end
    if (!rst && !exp_ctl[6]) n_cnt = m_cnt + 1;
  endfunction

  task automatic drive(input logic r, input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                       input logic [4:0] d, input logic rw, input logic m2r, input logic ms,
                       input logic br);
    rst = r; id_src1 = s1; id_src2 = s2; id_uses_src2 = u2; ex_dest_reg = d;
    ex_reg_write = rw; ex_mem2reg = m2r; ex_multi_start = ms; mem_branch_taken = br;
    #2;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    m_multi_left = n_multi_left;
    m_post_load  = n_post_load;
    m_cnt        = n_cnt;
    #1;
  endtask

  task automatic idle();
    drive(0, 5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    m_multi_left = 0; m_post_load = 0; m_cnt = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ctl_a !== 7'b0111110) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", ctl_a, 7'b0111110);
    end
    tick();
    idle();
    checks++;
    if (ctl_a !== exp_ctl) begin errors++; $display("FAIL post_reset_ctl: got %b want %b", ctl_a, exp_ctl); end
    checks++;
    if (cnt_a !== 16'd0 || cnt_b !== 4'd0) begin
      errors++; $display("FAIL post_reset_cnt: got %0d/%0d want 0/0", cnt_a, cnt_b);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [15:0] c0;
    drive(0, 5'd3, 5'd9, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    c0 = cnt_a;
    checks++;
    if (ctl_a !== 7'b0001100) begin errors++; $display("FAIL lu_stall: got %b want %b", ctl_a, 7'b0001100); end
    tick();
    drive(0, 5'd3, 5'd9, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== exp_ctl) begin errors++; $display("FAIL lu_second_cycle: got %b want %b", ctl_a, exp_ctl); end
    tick();
    idle();
    checks++;
    if (cnt_a !== c0 + 16'd1) begin errors++; $display("FAIL lu_count: got %0d want %0d", cnt_a, c0 + 16'd1); end
    tick();
  endtask

  task automatic test_no_hazard();
    drive(0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== 7'b1101000) begin errors++; $display("FAIL lu_r0: got %b want %b", ctl_a, 7'b1101000); end
    tick();
    drive(0, 5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== 7'b1101000) begin errors++; $display("FAIL lu_src2_unused: got %b want %b", ctl_a, 7'b1101000); end
    tick();
    drive(0, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== exp_ctl) begin errors++; $display("FAIL lu_src2_used: got %b want %b", ctl_a, exp_ctl); end
    tick();
    idle(); tick();
  endtask

  task automatic test_multi();
    int pc_low, busy_hi;
    logic [15:0] c0;
    pc_low = 0; busy_hi = 0;
    for (int k = 0; k < MC + 1; k++) begin
      // Spurious branch in the middle of the op must be ignored
      drive(0, 5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, (k == 0), (k == 1));
      if (k == 0) c0 = cnt_a;
      if (!a_pc) pc_low++;
      if (a_busy) busy_hi++;
      checks++;
      if (ctl_a !== exp_ctl) begin errors++; $display("FAIL multi_cycle%0d: got %b want %b", k, ctl_a, exp_ctl); end
      tick();
    end
    idle();
    checks++;
    if (pc_low != MC - 1 || busy_hi != MC) begin
      errors++; $display("FAIL multi_lengths: got pc_low=%0d busy=%0d want %0d/%0d", pc_low, busy_hi, MC - 1, MC);
    end
    checks++;
    if (cnt_a !== c0 + 16'(MC - 1)) begin errors++; $display("FAIL multi_count: got %0d want %0d", cnt_a, c0 + 16'(MC - 1)); end
    tick();
  endtask

  task automatic test_branch_priority();
    logic [15:0] c0;
    drive(0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    c0 = cnt_a;
    checks++;
    if (ctl_a !== 7'b1111110) begin errors++; $display("FAIL branch_flush: got %b want %b", ctl_a, 7'b1111110); end
    tick();
    idle();
    checks++;
    if (ctl_a !== 7'b1101000 || cnt_a !== c0) begin
      errors++; $display("FAIL branch_after: got %b cnt %0d want %b cnt %0d", ctl_a, cnt_a, 7'b1101000, c0);
    end
    tick();
  endtask

  task automatic test_reset_mid_multi();
    drive(0, 5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== 7'b0111110) begin errors++; $display("FAIL rst_mid_multi: got %b want %b", ctl_a, 7'b0111110); end
    tick();
    idle();
    checks++;
    if (ctl_a !== 7'b1101000 || cnt_a !== 16'd0) begin
      errors++; $display("FAIL rst_mid_after: got %b cnt %0d want %b cnt 0", ctl_a, cnt_a, 7'b1101000);
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int op = 0; op < 6; op++) begin
      for (int k = 0; k < MC; k++) begin
        drive(0, 5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, (k == 0), 1'b0);
        tick();
      end
      idle();
      if (op == 4) begin
        checks++;
        if (cnt_b !== 4'hF) begin errors++; $display("FAIL sat_reach: got %h want F", cnt_b); end
      end
    end
    checks++;
    if (cnt_b !== 4'hF || cnt_a !== 16'd18) begin
      errors++; $display("FAIL sat_hold: got %h/%0d want F/18", cnt_b, cnt_a);
    end
    tick();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0));
      checks++;
      if (ctl_a !== exp_ctl || ctl_b !== exp_ctl || cnt_a !== exp_a || cnt_b !== exp_b) begin
        errors++;
        if (bad < 10) $display("FAIL random_%0d: got %b/%b cnt %0d/%0d want %b cnt %0d/%0d",
                               i, ctl_a, ctl_b, cnt_a, cnt_b, exp_ctl, exp_a, exp_b);
        bad++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_multi();
    test_branch_priority();
    test_reset_mid_multi();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
